// File: rtl/txtrigger_gen.sv
// txtrigger_gen: programmable transmit-trigger pulse-train generator.
// On start it captures the configuration, waits CKINI clocks, then emits
// pulses of width max(PWIDTH,1) every max(CKPER, PW+1) clocks, either a
// finite count (NPER) or continuously until abort/reset.
module txtrigger_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NP_W  = 8,
  parameter int unsigned PW_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [CNT_W-1:0] CKINI,
  input  logic [CNT_W-1:0] CKPER,
  input  logic [NP_W-1:0]  NPER,
  input  logic [PW_W-1:0]  PWIDTH,
  output logic             txtrigger,
  output logic             busy,
  output logic             done,
  output logic [NP_W-1:0]  pcount
);

  typedef enum logic [1:0] {StIdle, StDelay, StPulse, StGap} state_e;

  state_e state_q, state_d;

  // cnt_q counts the initial delay, then the period of the current pulse
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_rld_q, per_rld_d;
  logic [PW_W-1:0]  pw_cnt_q, pw_cnt_d;
  logic [PW_W-1:0]  pw_rld_q, pw_rld_d;
  // Pulses still to issue after the current one (finite mode only)
  logic [NP_W-1:0]  np_cnt_q, np_cnt_d;
  logic             cont_q, cont_d;
  logic             txtrigger_d, busy_d, done_d;
  logic [NP_W-1:0]  pcount_d;

  logic [PW_W-1:0]  pw_eff;
  logic [CNT_W-1:0] pw_plus1;
  logic [CNT_W-1:0] per_eff;
  logic             start_ok;
  logic             empty_train;
  logic             pulse_end;
  logic             last_pulse;

  // Period is forced at least one clock longer than the pulse so a gap always exists
  assign pw_eff      = (PWIDTH == '0) ? PW_W'(1) : PWIDTH;
  assign pw_plus1    = CNT_W'(pw_eff) + CNT_W'(1);
  assign per_eff     = (CKPER >= pw_plus1) ? CKPER : pw_plus1;
  assign start_ok    = start & ~abort;
  assign empty_train = ~cont & (NPER == '0);
  assign pulse_end   = (pw_cnt_q == '0);
  assign last_pulse  = ~cont_q & (np_cnt_q == '0);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_ok && !empty_train) begin
          state_d = (CKINI == '0) ? StPulse : StDelay;
        end
      end
      StDelay: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (abort) begin
          state_d = StIdle;
        end else if (pulse_end) begin
          state_d = last_pulse ? StIdle : StGap;
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StPulse;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values for counters, captured config and registered outputs
  always_comb begin
    cnt_d       = cnt_q;
    per_rld_d   = per_rld_q;
    pw_cnt_d    = pw_cnt_q;
    pw_rld_d    = pw_rld_q;
    np_cnt_d    = np_cnt_q;
    cont_d      = cont_q;
    pcount_d    = pcount;
    txtrigger_d = txtrigger;
    busy_d      = busy;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          cont_d    = cont;
          per_rld_d = per_eff - CNT_W'(1);
          pw_rld_d  = pw_eff - PW_W'(1);
          np_cnt_d  = (NPER == '0) ? '0 : NPER - NP_W'(1);
          pcount_d  = '0;
          if (empty_train) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            if (CKINI == '0) begin
              // Zero delay: first pulse rises together with busy
              txtrigger_d = 1'b1;
              pcount_d    = NP_W'(1);
              pw_cnt_d    = pw_eff - PW_W'(1);
              cnt_d       = per_eff - CNT_W'(1);
            end else begin
              cnt_d = CKINI - CNT_W'(1);
            end
          end
        end
      end
      StDelay, StGap: begin
        if (abort) begin
          txtrigger_d = 1'b0;
          busy_d      = 1'b0;
        end else if (cnt_q == '0) begin
          txtrigger_d = 1'b1;
          pcount_d    = pcount + NP_W'(1);
          pw_cnt_d    = pw_rld_q;
          cnt_d       = per_rld_q;
          if (state_q == StGap && !cont_q) begin
            np_cnt_d = np_cnt_q - NP_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StPulse: begin
        if (abort) begin
          txtrigger_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (pulse_end) begin
            txtrigger_d = 1'b0;
            if (last_pulse) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end else begin
            pw_cnt_d = pw_cnt_q - PW_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      per_rld_q <= '0;
      pw_cnt_q  <= '0;
      pw_rld_q  <= '0;
      np_cnt_q  <= '0;
      cont_q    <= 1'b0;
      pcount    <= '0;
      txtrigger <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_rld_q <= per_rld_d;
      pw_cnt_q  <= pw_cnt_d;
      pw_rld_q  <= pw_rld_d;
      np_cnt_q  <= np_cnt_d;
      cont_q    <= cont_d;
      pcount    <= pcount_d;
      txtrigger <= txtrigger_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/txtrigger_gen.md
Name: txtrigger_gen

Overview:
Parametrised, multi-mode successor to the single-shot transmit-trigger controller. On `start` it captures a configuration set, waits an initial delay, then emits a train of transmit trigger pulses. Pulse width, period and count are programmable; the train can be finite or continuous. Sits between the control register block and the transmitter front-end. It reports `busy`, an end-of-train `done` strobe and a running pulse count.

Parameters:
CNT_W, 16, width of CKINI/CKPER and the internal delay/period counters
NP_W, 8, width of NPER and pcount
PW_W, 4, width of PWIDTH

Ports:
clock  input  1  master clock, rising edge
reset  input  1  asynchronous reset, active-low
start  input  1  begin a train; sampled only in IDLE
abort  input  1  synchronous abort, any state
cont  input  1  1 = continuous train (NPER ignored); captured at start
CKINI  input  CNT_W  clocks from busy rise to first pulse; captured at start
CKPER  input  CNT_W  rising-edge-to-rising-edge pulse period; captured at start
NPER  input  NP_W  pulses per train (finite mode); captured at start
PWIDTH  input  PW_W  pulse high time in clocks; captured at start
txtrigger  output  1  trigger pulse, registered
busy  output  1  high while a train is active, registered
done  output  1  single-cycle strobe at normal end of train
pcount  output  NP_W  pulses issued in current/last train

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state goes to IDLE;
  - txtrigger=0, busy=0, done=0, pcount=0;
  - all counters and captured config are cleared.
- FSM states: IDLE, DELAY, PULSE, GAP. All outputs come straight from registers; none depend combinationally on inputs.
- Effective values: PW = max(PWIDTH,1); P = max(CKPER, PW+1).
- Start: `start`=1 in IDLE at cycle T captures cont/CKINI/CKPER/NPER/PWIDTH and clears pcount.
  - Then busy=1 from T+1.
  - Pulse k (0-based) rises at T+1+CKINI+k*P and stays high for PW cycles.
  - CKINI=0 means txtrigger and busy rise in the same cycle.
- pcount increments in the cycle each pulse rises, so it is visible the same cycle as the rising txtrigger.
  - In continuous mode it wraps modulo 2^NP_W.
  - In finite mode it holds its final value until the next start.
- Finite end: the cycle after the last high cycle of pulse NPER-1 has busy=0 and done=1 for exactly one cycle; the FSM is in IDLE.
- A start asserted in that same done cycle is accepted; it behaves as a start in IDLE.
- NPER=0 with cont=0: no pulses and busy stays 0; done=1 at T+1; pcount=0.
- Continuous mode: the train runs indefinitely and ends only by abort or reset.
- start while busy is ignored. Config input changes while busy have no effect.
- Abort: `abort`=1 at cycle A in DELAY/PULSE/GAP gives, from A+1:
  - txtrigger=0, busy=0, state IDLE;
  - done is not asserted; pcount holds.
  - A pulse in progress is truncated.
  - In IDLE, abort has no effect.
- abort and start in the same IDLE cycle: abort wins, start is ignored.
- Counters load the captured value minus 1 and count down to 0.
  - No counter may underflow or wrap within a train.
  - CKINI, CKPER and NPER are all unsigned.

Test Plan:
1. CKINI=3, CKPER=5, NPER=3, PWIDTH=1, cont=0, start at cycle 10 -> txtrigger high at cycles 14, 19, 24 only; busy high 11..24; done=1 at 25 only; pcount=3 from 24.
2. CKINI=0, CKPER=4, NPER=2, PWIDTH=3, start at 10 -> txtrigger high 11..13 and 15..17; busy 11..17; done at 18.
3. Clamps: CKPER=2, PWIDTH=4, NPER=2, CKINI=0, start at 10 -> P=5; txtrigger high 11..14 and 16..19; done at 20. Also PWIDTH=0 gives 1-cycle pulses.
4. cont=1, CKINI=1, CKPER=3, NP_W=8, run 260 pulses -> pcount wraps 255→0→4. Abort during a pulse -> txtrigger and busy low the next cycle, no done, pcount holds.
5. NPER=0, cont=0, start at 10 -> busy never high; done at 11; no txtrigger. Start asserted during busy (test 1 at cycle 16) -> train unchanged.
6. Assert reset asynchronously mid-pulse, between clock edges -> txtrigger, busy, done and pcount are 0 immediately. After release, a start runs test 1's timing exactly.
